// File: rtl/frame_uart_tx_ctrl.sv
// Frame read-back: streams NUM_PIXELS 24-bit BRAM pixels out over uart_basic as R,G,B bytes.
// Define FRAME_HEADER_EN to prefix each frame with A5 5A NUM_PIXELS[15:8] NUM_PIXELS[7:0].
`timescale 1ns/1ps
module frame_uart_tx_ctrl #(
   parameter int NUM_PIXELS = 200704,
   parameter int ADDR_W     = 18,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [23:0]       rd_data,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {IDLE, HEADER, READ, WAIT_IDLE, WAIT_HI, WAIT_LO} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [31:0]       NPIX      = 32'(NUM_PIXELS);

   state_t      state;
   logic [1:0]  byte_idx;
   logic [1:0]  lat_cnt;
   logic [23:0] pixel;
`ifdef FRAME_HEADER_EN
   logic [1:0]  hdr_idx;
   logic        in_hdr;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         rd_addr  <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
         byte_idx <= 2'd0;
         lat_cnt  <= 2'd0;
         pixel    <= 24'h0;
`ifdef FRAME_HEADER_EN
         hdr_idx  <= 2'd0;
         in_hdr   <= 1'b0;
`endif
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         if (abort && state != IDLE) begin
            // Any byte already in the UART finishes on its own; we just drop back.
            state    <= IDLE;
            busy     <= 1'b0;
            rd_addr  <= '0;
            byte_idx <= 2'd0;
            lat_cnt  <= 2'd0;
`ifdef FRAME_HEADER_EN
            in_hdr   <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: if (start && !abort) begin
                  rd_addr <= '0;
                  busy    <= 1'b1;
                  lat_cnt <= 2'd0;
`ifdef FRAME_HEADER_EN
                  hdr_idx <= 2'd0;
                  in_hdr  <= 1'b1;
                  state   <= HEADER;
`else
                  state   <= READ;
`endif
               end
`ifdef FRAME_HEADER_EN
               HEADER: if (!tx_busy) begin
                  case (hdr_idx)
                     2'd0:    tx_data <= 8'hA5;
                     2'd1:    tx_data <= 8'h5A;
                     2'd2:    tx_data <= NPIX[15:8];
                     default: tx_data <= NPIX[7:0];
                  endcase
                  tx_start <= 1'b1;
                  state    <= WAIT_HI;
               end
`endif
               // rd_addr has been stable since entry; data lands RD_LATENCY cycles later.
               READ: if (lat_cnt == 2'(RD_LATENCY)) begin
                  pixel    <= rd_data;
                  byte_idx <= 2'd0;
                  lat_cnt  <= 2'd0;
                  state    <= WAIT_IDLE;
               end else begin
                  lat_cnt  <= lat_cnt + 2'd1;
               end
               WAIT_IDLE: if (!tx_busy) begin
                  case (byte_idx)
                     2'd0:    tx_data <= pixel[23:16];
                     2'd1:    tx_data <= pixel[15:8];
                     default: tx_data <= pixel[7:0];
                  endcase
                  tx_start <= 1'b1;
                  state    <= WAIT_HI;
               end
               WAIT_HI: if (tx_busy) state <= WAIT_LO;
               WAIT_LO: if (!tx_busy) begin
`ifdef FRAME_HEADER_EN
                  if (in_hdr) begin
                     if (hdr_idx == 2'd3) begin
                        in_hdr <= 1'b0;
                        state  <= READ;
                     end else begin
                        hdr_idx <= hdr_idx + 2'd1;
                        state   <= HEADER;
                     end
                  end else
`endif
                  if (byte_idx != 2'd2) begin
                     byte_idx <= byte_idx + 2'd1;
                     state    <= WAIT_IDLE;
                  end else if (rd_addr != LAST_ADDR) begin
                     rd_addr <= rd_addr + ADDR_W'(1);
                     lat_cnt <= 2'd0;
                     state   <= READ;
                  end else begin
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     rd_addr <= '0;
                     state   <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_uart_tx_ctrl.sv
// Random-data bench for frame_uart_tx_ctrl: one DUT per read latency (1 and 2), each with
// its own BRAM/UART model; byte streams are compared with a frame built from the pixel table.
`timescale 1ns/1ps
module tb_frame_uart_tx_ctrl;
   localparam int NP = 4;
   localparam int AW = 18;
`ifdef FRAME_HEADER_EN
   localparam int HDR = 4;
`else
   localparam int HDR = 0;
`endif
   localparam int FLEN = 3 * NP + HDR;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic [1:0]         start, abort, tx_start, tx_busy, busy, done;
   logic [1:0][AW-1:0] rd_addr;
   logic [1:0][23:0]   rd_data;
   logic [1:0][7:0]    tx_data;
   logic [23:0]        mem [NP];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [23:0] p1, p2;
      logic [7:0]  held;
      logic [7:0]  strm [256];
      int ns = 0, ndone = 0, ucnt = 0, len = 0, l;

      frame_uart_tx_ctrl #(.NUM_PIXELS(NP), .ADDR_W(AW), .RD_LATENCY(g + 1)) dut (
         .clk(clk), .resetn(resetn), .start(start[g]), .abort(abort[g]),
         .rd_addr(rd_addr[g]), .rd_data(rd_data[g]), .tx_start(tx_start[g]),
         .tx_data(tx_data[g]), .tx_busy(tx_busy[g]), .busy(busy[g]), .done(done[g]));

      always @(posedge clk) begin
         p1 <= mem[rd_addr[g][1:0]];
         p2 <= p1;
      end
      assign rd_data[g] = (g == 0) ? p1 : p2;
      assign tx_busy[g] = (ucnt != 0) && (ucnt <= len);

      // UART: busy rises 1..3 cycles after tx_start and lasts 1..12 cycles.
      always @(posedge clk) begin
         if (busy[g]) chk($sformatf("addr_range%0d", g), 32'(rd_addr[g] < AW'(NP)), 32'd1);
         if (ucnt != 0 && busy[g]) chk($sformatf("tx_data_hold%0d", g), 32'(tx_data[g]), 32'(held));
         if (tx_start[g]) begin
            chk($sformatf("no_overlap%0d", g), 32'(ucnt), 32'd0);
            l = int'($urandom_range(12, 1));
            len  <= l;
            ucnt <= l + int'($urandom_range(3, 1));
            held <= tx_data[g];
            strm[ns % 256] <= tx_data[g];
            ns   <= ns + 1;
         end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
         end
         if (done[g]) ndone <= ndone + 1;
      end
   end

   function automatic int ns_of(input int g);
      return (g == 0) ? g_dut[0].ns : g_dut[1].ns;
   endfunction
   function automatic int ndone_of(input int g);
      return (g == 0) ? g_dut[0].ndone : g_dut[1].ndone;
   endfunction
   function automatic int ucnt_of(input int g);
      return (g == 0) ? g_dut[0].ucnt : g_dut[1].ucnt;
   endfunction
   function automatic logic [7:0] byte_of(input int g, input int i);
      return (g == 0) ? g_dut[0].strm[i % 256] : g_dut[1].strm[i % 256];
   endfunction

   // Expected k-th byte of a frame: optional header, then each pixel MSB byte first.
   function automatic logic [7:0] exp_byte(input int k);
      logic [31:0] npv;
      logic [23:0] px;
      int          j;
      npv = NP;
      j   = k - HDR;
      if (k < HDR) begin
         case (k)
            0:       return 8'hA5;
            1:       return 8'h5A;
            2:       return npv[15:8];
            default: return npv[7:0];
         endcase
      end
      px = mem[j / 3];
      return 8'(px >> (8 * (2 - j % 3)));
   endfunction

   task automatic fill_mem();
      for (int i = 0; i < NP; i++) mem[i] = 24'($urandom);
   endtask

   task automatic uart_quiet(input int g);
      int c = 0;
      while (ucnt_of(g) != 0 && c < 100) begin @(negedge clk); c++; end
      chk("uart_quiet_timeout", 32'(c < 100), 32'd1);
   endtask

   task automatic pulse_start(input int g);
      @(negedge clk) start[g] = 1'b1;
      @(negedge clk) start[g] = 1'b0;
   endtask

   task automatic wait_bytes(input int g, input int base, input int n);
      int c = 0;
      while (ns_of(g) - base < n && c < 2000) begin @(negedge clk); c++; end
      chk("wait_bytes_timeout", 32'(c < 2000), 32'd1);
   endtask

   task automatic run_frame(input int g, input bit spam);
      int base, d0, c;
      base = ns_of(g);
      d0   = ndone_of(g);
      pulse_start(g);
      chk("busy_after_start", 32'(busy[g]), 32'd1);
      c = 0;
      while (ndone_of(g) == d0 && c < 5000) begin
         @(negedge clk);
         c++;
         start[g] = spam && busy[g] && ($urandom_range(3, 0) == 0);
      end
      start[g] = 1'b0;
      chk("done_timeout", 32'(c < 5000), 32'd1);
      chk("busy_after_done", 32'(busy[g]), 32'd0);
      chk("addr_after_done", 32'(rd_addr[g]), 32'd0);
      repeat (20) @(negedge clk);
      chk("done_count", 32'(ndone_of(g) - d0), 32'd1);
      chk("byte_count", 32'(ns_of(g) - base), 32'(FLEN));
      for (int k = 0; k < FLEN; k++)
         chk($sformatf("byte%0d_lat%0d", k, g + 1), 32'(byte_of(g, base + k)), 32'(exp_byte(k)));
      uart_quiet(g);
   endtask

   task automatic abort_test(input int g);
      int base, d0;
      base = ns_of(g);
      d0   = ndone_of(g);
      pulse_start(g);
      wait_bytes(g, base, 5);
      abort[g] = 1'b1;
      @(negedge clk) abort[g] = 1'b0;
      chk("abort_busy", 32'(busy[g]), 32'd0);
      chk("abort_addr", 32'(rd_addr[g]), 32'd0);
      chk("abort_txstart", 32'(tx_start[g]), 32'd0);
      repeat (60) @(negedge clk);
      chk("abort_bytes", 32'(ns_of(g) - base), 32'd5);
      chk("abort_no_done", 32'(ndone_of(g) - d0), 32'd0);
      for (int k = 0; k < 5; k++)
         chk("abort_prefix", 32'(byte_of(g, base + k)), 32'(exp_byte(k)));
      uart_quiet(g);
   endtask

   task automatic idle_start_abort(input int g);
      int base;
      base = ns_of(g);
      @(negedge clk) begin start[g] = 1'b1; abort[g] = 1'b1; end
      @(negedge clk) begin start[g] = 1'b0; abort[g] = 1'b0; end
      chk("idle_abort_busy", 32'(busy[g]), 32'd0);
      repeat (30) @(negedge clk);
      chk("idle_abort_bytes", 32'(ns_of(g) - base), 32'd0);
   endtask

   task automatic reset_test(input int g);
      int base;
      base = ns_of(g);
      pulse_start(g);
      wait_bytes(g, base, 7);
      repeat ($urandom_range(5, 0)) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("rst_txstart", 32'(tx_start[g]), 32'd0);
      chk("rst_busy", 32'(busy[g]), 32'd0);
      chk("rst_addr", 32'(rd_addr[g]), 32'd0);
      chk("rst_done", 32'(done[g]), 32'd0);
      @(negedge clk) resetn = 1'b1;
      uart_quiet(g);
   endtask

   initial begin
      resetn = 1'b0;
      start  = '0;
      abort  = '0;
      fill_mem();
      #22;
      for (int g = 0; g < 2; g++) begin
         chk("reset_busy", 32'(busy[g]), 32'd0);
         chk("reset_txstart", 32'(tx_start[g]), 32'd0);
         chk("reset_txdata", 32'(tx_data[g]), 32'd0);
         chk("reset_addr", 32'(rd_addr[g]), 32'd0);
         chk("reset_done", 32'(done[g]), 32'd0);
      end
      @(negedge clk) resetn = 1'b1;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("idle_busy", 32'(busy[g]), 32'd0);
         run_frame(g, 1'b0);
         fill_mem();
         run_frame(g, 1'b1);
         abort_test(g);
         run_frame(g, 1'b0);
         idle_start_abort(g);
         fill_mem();
         reset_test(g);
         run_frame(g, 1'b0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
